piso_frame_ctrl: RTL

Sequencer and round-robin arbiter for a parallel-in/serial-out shifter shared by several parallel-word requesters. Grants one requester at a time through a valid/ready handshake and loads the accepted word. Shifts it out MSB-first over WIDTH cycles, then inserts a programmable inter-frame gap. Sits between the parallel producers and the single serial line.

---
 rtl/piso_ctrl_pkg.sv | 20 ++
 rtl/piso_shift_reg.sv | 35 +++
 rtl/piso_frame_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/piso_ctrl_pkg.sv
// Shared types and sizing helpers for the PISO frame controller.
package piso_ctrl_pkg;

   // Sequencer states: waiting for a word, shifting a frame out, inter-frame gap.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   // Bits needed to hold values 0..n-1, never less than one bit.
   function automatic int cnt_w(input int n);
      if (n <= 2) begin
         return 1;
      end else begin
         return $clog2(n);
      end
   endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-load, serial-out shift register: MSB leaves first, zeros enter
// from the bottom, and a load always wins over a shift.
module piso_shift_reg
   import piso_ctrl_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] din,
   output logic             dout
);

   logic [WIDTH-1:0] data_r;

   // Load a new word or shift the current one left with zero fill.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_r <= {WIDTH{1'b0}};
      end else if (load) begin
         data_r <= din;
      end else if (shift) begin
         data_r <= {data_r[WIDTH-2:0], 1'b0};
      end else begin
         data_r <= data_r;
      end
   end

   // The serial bit comes straight from the top flop; it is zero once a
   // frame has fully drained, which keeps the line low between frames.
   assign dout = data_r[WIDTH-1];

endmodule

// File: rtl/piso_frame_ctrl.sv
// Round-robin sequencer that feeds several parallel requesters through one
// serial shifter, with a programmable idle gap after every frame.
module piso_frame_ctrl
   import piso_ctrl_pkg::*;
#(
   parameter int NREQ  = 2,
   parameter int WIDTH = 4,
   parameter int GAP   = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NREQ-1:0]               req_valid,
   input  logic [NREQ*WIDTH-1:0]         req_data,
   output logic [NREQ-1:0]               req_ready,
   output logic                          ser_out,
   output logic                          ser_valid,
   output logic                          frame_start,
   output logic [cnt_w(NREQ)-1:0]        grant_id,
   output logic                          busy
);

   localparam int GNT_W = cnt_w(NREQ);
   localparam int BIT_W = cnt_w(WIDTH);
   localparam int GAP_W = cnt_w(GAP);

   localparam logic [BIT_W-1:0] BIT_LOAD = BIT_W'(WIDTH - 1);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP > 0) ? (GAP - 1) : 0);
   localparam logic [GNT_W-1:0] GNT_LAST = GNT_W'(NREQ - 1);

   state_t             state_r;
   logic [BIT_W-1:0]   bit_cnt_r;
   logic [GAP_W-1:0]   gap_cnt_r;
   logic [GNT_W-1:0]   rr_ptr_r;
   logic [GNT_W-1:0]   grant_id_r;
   logic               ser_valid_r;
   logic               frame_start_r;
   logic               busy_r;

   logic               accept_s;
   logic               found_s;
   logic [GNT_W-1:0]   gnt_idx_s;
   logic [GNT_W-1:0]   rr_next_s;
   logic [NREQ-1:0]    req_ready_s;
   logic               xfer_s;
   logic               shift_s;
   logic [WIDTH-1:0]   word_sel_s;
   logic               shift_dout_s;

   // Accept slot: idle, the final gap cycle, or the final bit when there is no gap.
   always_comb begin
      accept_s = 1'b0;
      case (state_r)
         ST_IDLE:  accept_s = 1'b1;
         ST_GAP:   accept_s = (gap_cnt_r == {GAP_W{1'b0}});
         ST_SHIFT: accept_s = (GAP == 0) && (bit_cnt_r == {BIT_W{1'b0}});
         default:  accept_s = 1'b0;
      endcase
   end

   // Round-robin scan: first valid requester at or above rr_ptr, then wrap to zero.
   always_comb begin
      found_s   = 1'b0;
      gnt_idx_s = {GNT_W{1'b0}};
      for (int j = 0; j < NREQ; j++) begin
         if (!found_s && (j >= int'(rr_ptr_r)) && req_valid[j]) begin
            found_s   = 1'b1;
            gnt_idx_s = GNT_W'(j);
         end else begin
            found_s   = found_s;
         end
      end
      for (int j = 0; j < NREQ; j++) begin
         if (!found_s && (j < int'(rr_ptr_r)) && req_valid[j]) begin
            found_s   = 1'b1;
            gnt_idx_s = GNT_W'(j);
         end else begin
            found_s   = found_s;
         end
      end
   end

   // One-hot ready toward the winner, forced low while reset is held.
   always_comb begin
      req_ready_s = {NREQ{1'b0}};
      for (int j = 0; j < NREQ; j++) begin
         if (accept_s && found_s && !rst && (gnt_idx_s == GNT_W'(j))) begin
            req_ready_s[j] = 1'b1;
         end else begin
            req_ready_s[j] = 1'b0;
         end
      end
   end

   // Route the winner's word to the shifter input and precompute the pointer step.
   always_comb begin
      word_sel_s = {WIDTH{1'b0}};
      for (int j = 0; j < NREQ; j++) begin
         if (gnt_idx_s == GNT_W'(j)) begin
            word_sel_s = req_data[j*WIDTH +: WIDTH];
         end else begin
            word_sel_s = word_sel_s;
         end
      end
      if (gnt_idx_s == GNT_LAST) begin
         rr_next_s = {GNT_W{1'b0}};
      end else begin
         rr_next_s = gnt_idx_s + GNT_W'(1);
      end
   end

   assign xfer_s  = accept_s && found_s;
   assign shift_s = (state_r == ST_SHIFT);

   piso_shift_reg #(
      .WIDTH (WIDTH)
   ) u_shift (
      .clk   (clk),
      .rst   (rst),
      .load  (xfer_s),
      .shift (shift_s),
      .din   (word_sel_s),
      .dout  (shift_dout_s)
   );

   // Frame sequencer: state, bit/gap counters, arbitration pointer and line outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r       <= ST_IDLE;
         bit_cnt_r     <= {BIT_W{1'b0}};
         gap_cnt_r     <= {GAP_W{1'b0}};
         rr_ptr_r      <= {GNT_W{1'b0}};
         grant_id_r    <= {GNT_W{1'b0}};
         ser_valid_r   <= 1'b0;
         frame_start_r <= 1'b0;
         busy_r        <= 1'b0;
      end else begin
         frame_start_r <= xfer_s;
         if (xfer_s) begin
            grant_id_r <= gnt_idx_s;
            rr_ptr_r   <= rr_next_s;
         end else begin
            grant_id_r <= grant_id_r;
            rr_ptr_r   <= rr_ptr_r;
         end
         case (state_r)
            ST_IDLE: begin
               if (xfer_s) begin
                  state_r     <= ST_SHIFT;
                  bit_cnt_r   <= BIT_LOAD;
                  ser_valid_r <= 1'b1;
                  busy_r      <= 1'b1;
               end else begin
                  state_r     <= ST_IDLE;
                  ser_valid_r <= 1'b0;
                  busy_r      <= 1'b0;
               end
            end
            ST_SHIFT: begin
               if (bit_cnt_r != {BIT_W{1'b0}}) begin
                  bit_cnt_r   <= bit_cnt_r - BIT_W'(1);
                  ser_valid_r <= 1'b1;
                  busy_r      <= 1'b1;
               end else if (GAP > 0) begin
                  state_r     <= ST_GAP;
                  gap_cnt_r   <= GAP_LOAD;
                  ser_valid_r <= 1'b0;
                  busy_r      <= 1'b1;
               end else if (xfer_s) begin
                  state_r     <= ST_SHIFT;
                  bit_cnt_r   <= BIT_LOAD;
                  ser_valid_r <= 1'b1;
                  busy_r      <= 1'b1;
               end else begin
                  state_r     <= ST_IDLE;
                  ser_valid_r <= 1'b0;
                  busy_r      <= 1'b0;
               end
            end
            ST_GAP: begin
               if (gap_cnt_r != {GAP_W{1'b0}}) begin
                  gap_cnt_r   <= gap_cnt_r - GAP_W'(1);
                  ser_valid_r <= 1'b0;
                  busy_r      <= 1'b1;
               end else if (xfer_s) begin
                  state_r     <= ST_SHIFT;
                  bit_cnt_r   <= BIT_LOAD;
                  ser_valid_r <= 1'b1;
                  busy_r      <= 1'b1;
               end else begin
                  state_r     <= ST_IDLE;
                  ser_valid_r <= 1'b0;
                  busy_r      <= 1'b0;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               ser_valid_r <= 1'b0;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready   = req_ready_s;
   assign ser_out     = shift_dout_s;
   assign ser_valid   = ser_valid_r;
   assign frame_start = frame_start_r;
   assign grant_id    = grant_id_r;
   assign busy        = busy_r;

endmodule
